uart_fifo_gen: RTL and testbench
================================

// Module: uart_fifo_gen
// PURPOSE
//  Parametrised synchronous FIFO for the UART TX/RX data paths; next generation of the byte FIFO.
//  Adds generic data width/depth, a programmable near-full threshold, a sticky overflow flag,
//  a sticky underflow flag and a selectable drop-new/overwrite-oldest policy when full.
//  Sits between the UART byte engines and the host-side register interface; single clock domain.
// PARAMETERS
//  DATA_W     8     data word width, >=1
//  DEPTH      4096  storage words; power of two, >=4
//  OVERWRITE  0     0: write to a full FIFO is dropped; 1: write replaces the oldest word
//  (derived)  AW=$clog2(DEPTH), CW=AW+1 (count width)
// PORTS
//  clk           in   1       system clock
//  rst           in   1       reset, synchronous, active-low
//  n_clr_i       in   1       synchronous clear, active-low
//  data_i        in   DATA_W  write data
//  n_we_i        in   1       write strobe, active-low, one word per cycle
//  n_re_i        in   1       read strobe, active-low, one word per cycle
//  nf_level_i    in   CW      near-full threshold, quasi-static
//  data_o        out  DATA_W  read data, registered
//  count_o       out  CW      words stored, 0..DEPTH
//  p_empty_o     out  1       count_o==0
//  p_full_o      out  1       count_o==DEPTH
//  p_nearfull_o  out  1       count_o>=nf_level_i
//  p_over_o      out  1       sticky: a write hit a full FIFO without a same-cycle read
//  p_under_o     out  1       sticky: a read hit an empty FIFO
// BEHAVIOUR
//  - Reset (rst=0 at posedge): wr_ptr=rd_ptr=0, count=0, data_o=0, p_empty_o=1, all other flags 0.
//    Memory array is not reset. Reset has priority over every other input; applying it mid-stream discards contents.
//  - n_clr_i=0: same effect as reset on the next edge; priority over we/re that cycle.
//  - Pointers are AW bits and wrap DEPTH-1 -> 0 naturally; count is a separate CW-bit register.
//  - All flags are decoded from the count register and the sticky bits: they change on the edge after the access.
//  - Read accepted when n_re_i=0 and count!=0: data_o <= mem[rd_ptr] on that edge (1-cycle latency),
//    rd_ptr++. Otherwise data_o holds its value.
//  - Read with count==0: rejected, no pointer move, p_under_o <= 1. No fall-through: a same-cycle write into an empty FIFO is not readable that cycle.
//  - Write accepted when n_we_i=0 and (count<DEPTH or a read is accepted this cycle): mem[wr_ptr] <= data_i, wr_ptr++.
//  - Write with count==DEPTH and no accepted read:
//    OVERWRITE=0: word dropped, pointers unchanged, p_over_o <= 1.
//    OVERWRITE=1: mem[wr_ptr] <= data_i, wr_ptr++, rd_ptr++ (oldest lost), count unchanged, p_over_o <= 1.
//  - Count: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
//    The overwrite case counts as "both".
//  - Sticky flags clear only on reset or n_clr_i.
//  - nf_level_i=0 gives p_nearfull_o=1 always; nf_level_i>DEPTH gives 0 always.
// CONFIGURATION
//  UART_FIFO_TMR_EN defined: wr_ptr, rd_ptr, count and both sticky bits are held in three copies.
//    The next state of each copy is computed from the bitwise 2-of-3 majority vote of the copies.
//    All outputs and the memory address use the voted value, so a single-copy upset self-heals in one clock.
//  Not defined: single copies; function and timing identical.
// STRUCTURE
//  Package uart_fifo_pkg: function clog2, function maj3(a,b,c) = bitwise (a&b)|(b&c)|(c&a), DEPTH legality check.
//  Sub-module uart_fifo_vote #(W): three W-bit inputs, one voted W-bit output. Instantiated only under UART_FIFO_TMR_EN.
//  Storage is a plain reg array with a synchronous write port and a registered read port, inferable as block RAM.
// TESTING (DATA_W=8, DEPTH=8 unless noted)
//  1 Reset: rst=0 for 2 clk, then write 0x11,0x22,0x33 and read 3 -> data_o 0x11,0x22,0x33 on the edges after each read;
//    count 3->0; p_empty_o=1.
//  2 Fill: 8 writes -> p_full_o=1, count=8. 9th write with OVERWRITE=0 -> dropped, p_over_o=1;
//    readback returns the first 8 words.
//  3 OVERWRITE=1: write 0..9 -> count=8, p_over_o=1, readback 2..9.
//  4 Simultaneous: at count=8, write and read together -> both accepted, count stays 8, p_over_o stays 0.
//    At count=0, write and read together -> read rejected, p_under_o=1, count=1.
//  5 Wrap and near-full: nf_level_i=6; 20 write/read cycles crossing the pointer wrap -> data order is preserved;
//    p_nearfull_o rises on the edge where count reaches 6.
//  6 Clear and TMR: n_clr_i=0 at count=5 -> count=0, sticky flags 0.
//    With UART_FIFO_TMR_EN, force one wr_ptr copy to 0x5 -> output data is unaffected and the copies re-agree after 1 clk.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared helpers for the UART FIFO: width math, bitwise majority vote and
// the storage-depth legality check.
package uart_fifo_pkg;

    // Ceiling log2 for sizing pointers from the storage depth.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // 2-of-3 majority of one bit; applied per bit by the voter.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (b & c) | (c & a);
    endfunction

    // Depth must be a power of two so the pointers wrap for free.
    function automatic bit depth_ok(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_fifo_vote.sv
// Bitwise 2-of-3 majority voter for triplicated FIFO state.
module uart_fifo_vote
    import uart_fifo_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign y[gi] = maj3(a[gi], b[gi], c[gi]);
        end
    endgenerate

endmodule

// File: rtl/uart_fifo_gen.sv
// Parametrised synchronous FIFO for the UART data paths with near-full
// threshold, sticky overflow/underflow flags and drop-new/overwrite-oldest
// policy. Optional macro UART_FIFO_TMR_EN triplicates pointers, count and
// sticky bits with majority voting so a single-copy upset heals in one clock.
module uart_fifo_gen
    import uart_fifo_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 4096,
    parameter  int OVERWRITE = 0,
    localparam int AW        = clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              n_clr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              n_we_i,
    input  logic              n_re_i,
    input  logic [CW-1:0]     nf_level_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CW-1:0]     count_o,
    output logic              p_empty_o,
    output logic              p_full_o,
    output logic              p_nearfull_o,
    output logic              p_over_o,
    output logic              p_under_o
);

    generate
        if (!depth_ok(DEPTH)) begin : g_bad_depth
            $error("uart_fifo_gen: DEPTH must be a power of two and >= 4");
        end
    endgenerate

`ifdef UART_FIFO_TMR_EN
    localparam int NCOPY = 3;
`else
    localparam int NCOPY = 1;
`endif

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg [NCOPY];
    logic [AW-1:0] rd_ptr_reg [NCOPY];
    logic [CW-1:0] count_reg  [NCOPY];
    logic          over_reg   [NCOPY];
    logic          under_reg  [NCOPY];

    logic [AW-1:0] wr_ptr_v, rd_ptr_v, wr_ptr_next, rd_ptr_next;
    logic [CW-1:0] count_v, count_next;
    logic          over_v, under_v, over_next, under_next;
    logic          clear, is_full, is_empty, rd_acc, wr_acc, ovw, mem_we;
    logic [DATA_W-1:0] data_reg;

`ifdef UART_FIFO_TMR_EN
    uart_fifo_vote #(.W(AW)) u_vote_wr (.a(wr_ptr_reg[0]), .b(wr_ptr_reg[1]), .c(wr_ptr_reg[2]), .y(wr_ptr_v));
    uart_fifo_vote #(.W(AW)) u_vote_rd (.a(rd_ptr_reg[0]), .b(rd_ptr_reg[1]), .c(rd_ptr_reg[2]), .y(rd_ptr_v));
    uart_fifo_vote #(.W(CW)) u_vote_cnt (.a(count_reg[0]), .b(count_reg[1]), .c(count_reg[2]), .y(count_v));
    uart_fifo_vote #(.W(1))  u_vote_ov (.a(over_reg[0]), .b(over_reg[1]), .c(over_reg[2]), .y(over_v));
    uart_fifo_vote #(.W(1))  u_vote_un (.a(under_reg[0]), .b(under_reg[1]), .c(under_reg[2]), .y(under_v));
`else
    assign wr_ptr_v = wr_ptr_reg[0];
    assign rd_ptr_v = rd_ptr_reg[0];
    assign count_v  = count_reg[0];
    assign over_v   = over_reg[0];
    assign under_v  = under_reg[0];
`endif

    // Access acceptance and next-state arithmetic, all from the voted state.
    always_comb begin
        clear    = !rst || !n_clr_i;
        is_full  = (count_v == FULL_COUNT);
        is_empty = (count_v == '0);
        rd_acc   = !n_re_i && !is_empty;
        wr_acc   = !n_we_i && (!is_full || rd_acc);
        // Write into a full FIFO with no read: dropped, or replaces the oldest word.
        ovw      = (OVERWRITE != 0) && !n_we_i && is_full && !rd_acc;
        mem_we   = wr_acc || ovw;

        wr_ptr_next = mem_we ? wr_ptr_v + 1'b1 : wr_ptr_v;
        rd_ptr_next = (rd_acc || ovw) ? rd_ptr_v + 1'b1 : rd_ptr_v;

        count_next = count_v;
        if (wr_acc && !rd_acc) begin
            count_next = count_v + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_next = count_v - 1'b1;
        end

        over_next  = over_v  || (!n_we_i && is_full && !rd_acc);
        under_next = under_v || (!n_re_i && is_empty);
    end

    // State copies; each one reloads from the voted next state.
    genvar gi;
    generate
        for (gi = 0; gi < NCOPY; gi++) begin : g_copy
            always_ff @(posedge clk) begin
                if (clear) begin
                    wr_ptr_reg[gi] <= '0;
                    rd_ptr_reg[gi] <= '0;
                    count_reg[gi]  <= '0;
                    over_reg[gi]   <= 1'b0;
                    under_reg[gi]  <= 1'b0;
                end else begin
                    wr_ptr_reg[gi] <= wr_ptr_next;
                    rd_ptr_reg[gi] <= rd_ptr_next;
                    count_reg[gi]  <= count_next;
                    over_reg[gi]   <= over_next;
                    under_reg[gi]  <= under_next;
                end
            end
        end
    endgenerate

    // Storage write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (mem_we && !clear) begin
            mem[wr_ptr_v] <= data_i;
        end
    end

    // Registered read port; holds its value when no read is accepted.
    always_ff @(posedge clk) begin
        if (clear) begin
            data_reg <= '0;
        end else if (rd_acc) begin
            data_reg <= mem[rd_ptr_v];
        end
    end

    assign data_o       = data_reg;
    assign count_o      = count_v;
    assign p_empty_o    = is_empty;
    assign p_full_o     = is_full;
    assign p_nearfull_o = (count_v >= nf_level_i);
    assign p_over_o     = over_v;
    assign p_under_o    = under_v;

endmodule

// File: tb/tb_uart_fifo_gen.sv
// Directed bench for uart_fifo_gen at DATA_W=8, DEPTH=8. Two instances share
// the stimulus: dut0 drops writes into a full FIFO, dut1 overwrites the oldest.
// The UART_FIFO_TMR_EN section exercises the triplicated state when defined.
module tb_uart_fifo_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       n_clr = 1'b1;
    logic [7:0] din = 8'h00;
    logic       n_we = 1'b1;
    logic       n_re = 1'b1;
    logic [3:0] nf = 4'd6;

    logic [7:0] d0, d1;
    logic [3:0] c0, c1;
    logic       e0, f0, nf0, ov0, un0;
    logic       e1, f1, nf1, ov1, un1;

    int total = 0;
    int bad   = 0;
    logic [7:0] q[$];
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    uart_fifo_gen #(.DATA_W(8), .DEPTH(8), .OVERWRITE(0)) dut0 (
        .clk(clk), .rst(rst), .n_clr_i(n_clr), .data_i(din), .n_we_i(n_we),
        .n_re_i(n_re), .nf_level_i(nf), .data_o(d0), .count_o(c0),
        .p_empty_o(e0), .p_full_o(f0), .p_nearfull_o(nf0), .p_over_o(ov0),
        .p_under_o(un0));

    uart_fifo_gen #(.DATA_W(8), .DEPTH(8), .OVERWRITE(1)) dut1 (
        .clk(clk), .rst(rst), .n_clr_i(n_clr), .data_i(din), .n_we_i(n_we),
        .n_re_i(n_re), .nf_level_i(nf), .data_o(d1), .count_o(c1),
        .p_empty_o(e1), .p_full_o(f1), .p_nearfull_o(nf1), .p_over_o(ov1),
        .p_under_o(un1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle from a negedge, return at the next negedge.
    task automatic step(input logic we, input logic re, input logic [7:0] d);
        n_we = !we;
        n_re = !re;
        din  = d;
        @(posedge clk);
        @(negedge clk);
        n_we = 1'b1;
        n_re = 1'b1;
        $display("step we=%0b re=%0b din=%02h -> d0=%02h c0=%0d d1=%02h c1=%0d", we, re, d, d0, c0, d1, c1);
    endtask

    task automatic do_clear();
        n_clr = 1'b0;
        step(1'b1, 1'b1, 8'hEE);
        n_clr = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        // 1: reset and short write/read
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("rst_count", c0, 0);
        chk("rst_empty", e0, 1);
        chk("rst_data", d0, 0);
        chk("rst_flags", {f0, nf0, ov0, un0}, 4'b0000);
        chk("rst_flags1", {e1, f1, ov1, un1}, 4'b1000);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        chk("t1_count3", c0, 3);
        step(1'b0, 1'b1, 8'h00);
        chk("t1_rd0", d0, 8'h11);
        chk("t1_count2", c0, 2);
        step(1'b0, 1'b1, 8'h00);
        chk("t1_rd1", d0, 8'h22);
        step(1'b0, 1'b1, 8'h00);
        chk("t1_rd2", d0, 8'h33);
        chk("t1_rd2_ovw", d1, 8'h33);
        chk("t1_count0", c0, 0);
        chk("t1_empty", e0, 1);

        // 2: fill, near-full edge, drop vs overwrite on the 9th write
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'hA0 + 8'(i));
            if (i == 4) chk("t2_nf_below", nf0, 0);
            if (i == 5) chk("t2_nf_rise", nf0, 1);
        end
        chk("t2_full", f0, 1);
        chk("t2_count8", c0, 8);
        chk("t2_over_pre", ov0, 0);
        nf = 4'd9; #1;
        chk("t2_nf_gt_depth", nf0, 0);
        nf = 4'd8; #1;
        chk("t2_nf_eq_depth", nf0, 1);
        nf = 4'd6;
        step(1'b1, 1'b0, 8'hA8);
        chk("t2_drop_count", c0, 8);
        chk("t2_drop_over", ov0, 1);
        chk("t2_ovw_count", c1, 8);
        chk("t2_ovw_over", ov1, 1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("t2_rd_drop", d0, 8'hA0 + 8'(i));
            chk("t2_rd_ovw", d1, 8'hA1 + 8'(i));
        end
        chk("t2_empty", e0, 1);
        step(1'b0, 1'b1, 8'h00);
        chk("t2_under", un0, 1);
        chk("t2_under_hold", d0, 8'hA7);
        chk("t2_under_count", c0, 0);
        nf = 4'd0; #1;
        chk("t2_nf_zero", nf0, 1);
        nf = 4'd6;

        // 3: write 0..9 into both
        do_clear();
        chk("t3_clr_sticky", {ov0, un0, ov1, un1}, 4'b0000);
        chk("t3_clr_data", d0, 0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(i));
        chk("t3_count", c1, 8);
        chk("t3_over", ov1, 1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("t3_rd_ovw", d1, 8'(i + 2));
            chk("t3_rd_drop", d0, 8'(i));
        end

        // 4: simultaneous access at full and at empty
        do_clear();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
        step(1'b1, 1'b1, 8'h50);
        chk("t4_full_both_count", c0, 8);
        chk("t4_full_both_over", ov0, 0);
        chk("t4_full_both_over1", ov1, 0);
        chk("t4_full_both_data", d0, 8'h40);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            exp_d = (i == 7) ? 8'h50 : 8'h41 + 8'(i);
            chk("t4_rd", d0, exp_d);
        end
        step(1'b1, 1'b1, 8'h60);
        chk("t4_empty_both_under", un0, 1);
        chk("t4_empty_both_count", c0, 1);
        chk("t4_empty_both_data", d0, 8'h50);
        step(1'b0, 1'b1, 8'h00);
        chk("t4_late_rd", d0, 8'h60);
        chk("t4_late_count", c0, 0);

        // 5: streaming across the pointer wrap
        do_clear();
        q.delete();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h80 + 8'(i));
            q.push_back(8'h80 + 8'(i));
        end
        for (int k = 3; k < 23; k++) begin
            step(1'b1, 1'b1, 8'h80 + 8'(k));
            q.push_back(8'h80 + 8'(k));
            exp_d = q.pop_front();
            chk("t5_stream", d0, exp_d);
        end
        chk("t5_count", c0, 3);
        chk("t5_over", ov0, 0);

        // 6: clear mid-stream wipes contents and sticky bits
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
        chk("t6_under_set", un0, 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
        chk("t6_count5", c0, 5);
        n_clr = 1'b0;
        step(1'b1, 1'b1, 8'hDD);
        n_clr = 1'b1;
        chk("t6_clr_count", c0, 0);
        chk("t6_clr_flags", {e0, ov0, un0}, 3'b100);
        chk("t6_clr_data", d0, 0);

`ifdef UART_FIFO_TMR_EN
        step(1'b1, 1'b0, 8'h71);
        step(1'b1, 1'b0, 8'h72);
        step(1'b1, 1'b0, 8'h73);
        force dut0.wr_ptr_reg[0] = 3'h5;
        #1;
        release dut0.wr_ptr_reg[0];
        #1;
        chk("tmr_count_masked", c0, 3);
        step(1'b0, 1'b0, 8'h00);
        chk("tmr_healed", dut0.wr_ptr_reg[0], 3'h3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("tmr_rd", d0, 8'h71 + 8'(i));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
